weight_dump_tx: RTL and testbench

//  Reads the loaded softmax model back out of weight_loader's read ports and

---
 rtl/weight_dump_tx.sv | 195 +++++++++++++++++++
 tb/tb_weight_dump_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_dump_tx.sv
// weight_dump_tx: reads the weight/bias BRAMs back and streams them as a framed byte dump to uart_tx.
// Define DUMP_CHECKSUM_EN to append a mod-256 payload checksum byte before the trailer.
module weight_dump_tx #(
    parameter int N_WEIGHTS = 7840,
    parameter int N_BIASES  = 10,
    parameter int RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        weights_loaded,
    output logic [12:0] weight_rd_addr,
    input  logic [7:0]  weight_rd_data,
    output logic [3:0]  bias_rd_addr,
    input  logic [31:0] bias_rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_HDR0    = 4'd1;
    localparam logic [3:0] S_HDR1    = 4'd2;
    localparam logic [3:0] S_W_FETCH = 4'd3;
    localparam logic [3:0] S_W_WAIT  = 4'd4;
    localparam logic [3:0] S_W_SEND  = 4'd5;
    localparam logic [3:0] S_B_FETCH = 4'd6;
    localparam logic [3:0] S_B_WAIT  = 4'd7;
    localparam logic [3:0] S_B_SEND  = 4'd8;
    localparam logic [3:0] S_TRL0    = 4'd9;
    localparam logic [3:0] S_TRL1    = 4'd10;
`ifdef DUMP_CHECKSUM_EN
    localparam logic [3:0] S_CSUM    = 4'd11;
    localparam logic [3:0] S_AFTER_B = S_CSUM;
`else
    localparam logic [3:0] S_AFTER_B = S_TRL0;
`endif

    localparam int              WCW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(RD_LAT - 1);
    localparam logic [12:0]     W_LAST    = 13'(N_WEIGHTS - 1);
    localparam logic [3:0]      B_LAST    = 4'(N_BIASES - 1);

    logic [3:0]     state;
    logic [12:0]    w_idx;
    logic [3:0]     b_idx;
    logic [1:0]     byte_sel;
    logic [WCW-1:0] wait_cnt;
    logic [31:0]    bias_hold;
    logic           xfer;
    logic           accept;

    assign xfer   = tx_valid & tx_ready;
    assign accept = (state == S_IDLE) & start & weights_loaded;

`ifdef DUMP_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            csum <= 8'h00;
        else if (accept)
            csum <= 8'h00;
        else if (xfer && (state == S_W_SEND || state == S_B_SEND))
            csum <= csum + tx_data;
    end
`endif

    // Every send state uses two phases: present the byte while tx_valid is low,
    // then hold it until the transfer and drop tx_valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            w_idx          <= 13'd0;
            b_idx          <= 4'd0;
            byte_sel       <= 2'd0;
            wait_cnt       <= '0;
            bias_hold      <= 32'd0;
            weight_rd_addr <= 13'd0;
            bias_rd_addr   <= 4'd0;
            tx_data        <= 8'h00;
            tx_valid       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    state    <= S_HDR0;
                    busy     <= 1'b1;
                    w_idx    <= 13'd0;
                    b_idx    <= 4'd0;
                    byte_sel <= 2'd0;
                end
                S_HDR0: if (!tx_valid) begin
                    tx_data  <= 8'hAA;
                    tx_valid <= 1'b1;
                end else if (tx_ready) begin
                    tx_valid <= 1'b0;
                    state    <= S_HDR1;
                end
                S_HDR1: if (!tx_valid) begin
                    tx_data  <= 8'h55;
                    tx_valid <= 1'b1;
                end else if (tx_ready) begin
                    tx_valid <= 1'b0;
                    state    <= S_W_FETCH;
                end
                S_W_FETCH: begin
                    weight_rd_addr <= w_idx;
                    wait_cnt       <= '0;
                    state          <= S_W_WAIT;
                end
                S_W_WAIT: if (wait_cnt == WAIT_LAST) begin
                    state <= S_W_SEND;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                S_W_SEND: if (!tx_valid) begin
                    tx_data  <= weight_rd_data;
                    tx_valid <= 1'b1;
                end else if (tx_ready) begin
                    tx_valid <= 1'b0;
                    w_idx    <= w_idx + 13'd1;
                    if (w_idx == W_LAST) begin
                        b_idx <= 4'd0;
                        state <= S_B_FETCH;
                    end else begin
                        state <= S_W_FETCH;
                    end
                end
                S_B_FETCH: begin
                    bias_rd_addr <= b_idx;
                    wait_cnt     <= '0;
                    byte_sel     <= 2'd0;
                    state        <= S_B_WAIT;
                end
                S_B_WAIT: if (wait_cnt == WAIT_LAST) begin
                    state <= S_B_SEND;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                S_B_SEND: if (!tx_valid) begin
                    // Read data is only guaranteed on the first send cycle, so capture it then.
                    if (byte_sel == 2'd0) begin
                        bias_hold <= bias_rd_data;
                        tx_data   <= bias_rd_data[7:0];
                    end else begin
                        tx_data <= bias_hold[{byte_sel, 3'b000} +: 8];
                    end
                    tx_valid <= 1'b1;
                end else if (tx_ready) begin
                    tx_valid <= 1'b0;
                    byte_sel <= byte_sel + 2'd1;
                    if (byte_sel == 2'd3) begin
                        if (b_idx == B_LAST) begin
                            state <= S_AFTER_B;
                        end else begin
                            b_idx <= b_idx + 4'd1;
                            state <= S_B_FETCH;
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                S_CSUM: if (!tx_valid) begin
                    tx_data  <= csum;
                    tx_valid <= 1'b1;
                end else if (tx_ready) begin
                    tx_valid <= 1'b0;
                    state    <= S_TRL0;
                end
`endif
                S_TRL0: if (!tx_valid) begin
                    tx_data  <= 8'h55;
                    tx_valid <= 1'b1;
                end else if (tx_ready) begin
                    tx_valid <= 1'b0;
                    state    <= S_TRL1;
                end
                S_TRL1: if (!tx_valid) begin
                    tx_data  <= 8'hAA;
                    tx_valid <= 1'b1;
                end else if (tx_ready) begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_dump_tx.sv
// tb_weight_dump_tx: drives weight_dump_tx from BRAM models and checks the byte stream
// against a frame built directly from the memory contents.
module tb_weight_dump_tx;
    localparam int NW    = 300;
    localparam int NB    = 10;
    localparam int LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        weights_loaded = 1'b1;
    logic [12:0] weight_rd_addr;
    logic [7:0]  weight_rd_data = 8'h00;
    logic [3:0]  bias_rd_addr;
    logic [31:0] bias_rd_data = 32'h0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        done;

    logic [7:0]  wmem [NW];
    logic [31:0] bmem [NB];
    logic [7:0]  exp_q [$];
    logic [7:0]  rx_q  [$];
    int          rx_cnt = 0;
    int          done_cnt = 0;
    int          ready_pct = 100;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    weight_dump_tx #(.N_WEIGHTS(NW), .N_BIASES(NB), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .weights_loaded(weights_loaded),
        .weight_rd_addr(weight_rd_addr), .weight_rd_data(weight_rd_data),
        .bias_rd_addr(bias_rd_addr), .bias_rd_data(bias_rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // synchronous-read BRAM models
    always @(posedge clk) begin
        weight_rd_data <= (weight_rd_addr < NW) ? wmem[weight_rd_addr] : 8'hxx;
        bias_rd_data   <= (bias_rd_addr < NB) ? bmem[bias_rd_addr] : 32'hx;
    end

    initial forever begin
        @(posedge clk);
        #1 tx_ready = ($urandom_range(99) < ready_pct);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame straight from the memory contents and the wire-order rule.
    task automatic build_frame();
        logic [7:0] sum;
        sum = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        for (int k = 0; k < NW; k++) begin
            exp_q.push_back(wmem[k]);
            sum = sum + wmem[k];
        end
        for (int b = 0; b < NB; b++)
            for (int j = 0; j < 4; j++) begin
                exp_q.push_back(bmem[b][8*j +: 8]);
                sum = sum + bmem[b][8*j +: 8];
            end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_valid", int'(tx_valid), 1);
                chk("hold_data", int'(tx_data), int'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                if (rx_cnt < exp_q.size())
                    chk("byte", int'(tx_data), int'(exp_q[rx_cnt]));
                else
                    chk("extra_byte", rx_cnt, exp_q.size() - 1);
                chk("busy_during_tx", int'(busy), 1);
                rx_q.push_back(tx_data);
                rx_cnt++;
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", int'(busy), 0);
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic start_frame(input int pct);
        build_frame();
        rx_q.delete();
        rx_cnt    = 0;
        done_cnt  = 0;
        ready_pct = pct;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < LIMIT && rx_cnt < n; i++) @(negedge clk);
        chk("reach_byte", int'(rx_cnt >= n), 1);
    endtask

    task automatic finish_frame(input string name);
        for (int i = 0; i < LIMIT && done_cnt == 0; i++) @(negedge clk);
        chk({name, "_done_seen"}, int'(done_cnt > 0), 1);
        repeat (5) @(negedge clk);
        chk({name, "_len"}, rx_cnt, exp_q.size());
        chk({name, "_done_once"}, done_cnt, 1);
        chk({name, "_busy_after"}, int'(busy), 0);
        chk({name, "_valid_after"}, int'(tx_valid), 0);
    endtask

    task automatic load_counting();
        for (int k = 0; k < NW; k++) wmem[k] = 8'(k);
        for (int b = 0; b < NB; b++) bmem[b] = 32'h1000_0000 + 32'(b);
    endtask

    initial begin
        int last;
        int seen;
        load_counting();
        build_frame();
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(tx_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_data", int'(tx_data), 0);
        chk("rst_waddr", int'(weight_rd_addr), 0);
        chk("rst_baddr", int'(bias_rd_addr), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // counting pattern, ready always high; hand-computed bytes pin the model
        start_frame(100);
        @(negedge clk);
        chk("busy_after_start", int'(busy), 1);
        finish_frame("t1");
        last = rx_q.size() - 1;
        chk("t1_hdr0", int'(rx_q[0]), 8'hAA);
        chk("t1_hdr1", int'(rx_q[1]), 8'h55);
        chk("t1_w0", int'(rx_q[2]), 8'h00);
        chk("t1_w1", int'(rx_q[3]), 8'h01);
        chk("t1_w255", int'(rx_q[2+255]), 8'hFF);
        chk("t1_w256", int'(rx_q[2+256]), 8'h00);
        chk("t1_b0_lo", int'(rx_q[2+NW]), 8'h00);
        chk("t1_b0_hi", int'(rx_q[2+NW+3]), 8'h10);
        chk("t1_b1_lo", int'(rx_q[2+NW+4]), 8'h01);
        chk("t1_trl0", int'(rx_q[last-1]), 8'h55);
        chk("t1_trl1", int'(rx_q[last]), 8'hAA);

        // start while weights not loaded is ignored
        weights_loaded = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_valid || busy) seen++;
        end
        chk("t2_idle_cycles_active", seen, 0);
        weights_loaded = 1'b1;

        // 30% ready; weights_loaded drops mid-dump without effect
        start_frame(30);
        repeat (20) @(negedge clk);
        weights_loaded = 1'b0;
        finish_frame("t3");
        weights_loaded = 1'b1;

        // second start pulse mid-frame is ignored
        start_frame(100);
        wait_bytes(100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_frame("t4");
        repeat (30) @(negedge clk);
        chk("t4_no_second_frame", rx_cnt, exp_q.size());

        // reset mid-frame, then a clean restart
        start_frame(100);
        wait_bytes(200);
        #2 rst_n = 1'b0;
        #1 chk("t5_valid_async", int'(tx_valid), 0);
        chk("t5_busy_async", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rx_cnt = 0;
        repeat (20) @(negedge clk);
        chk("t5_silent_after_rst", rx_cnt, 0);
        start_frame(100);
        finish_frame("t5r");
        chk("t5r_hdr0", int'(rx_q[0]), 8'hAA);
        chk("t5r_hdr1", int'(rx_q[1]), 8'h55);

        // all-ones pattern: trailer position and (when enabled) checksum value
        for (int k = 0; k < NW; k++) wmem[k] = 8'h01;
        for (int b = 0; b < NB; b++) bmem[b] = 32'h0000_0001;
        start_frame(100);
        finish_frame("t6");
        last = rx_q.size() - 1;
`ifdef DUMP_CHECKSUM_EN
        chk("t6_csum", int'(rx_q[last-2]), (NW + NB) & 8'hFF);
`else
        chk("t6_last_bias_hi", int'(rx_q[last-2]), 8'h00);
`endif
        chk("t6_trl0", int'(rx_q[last-1]), 8'h55);
        chk("t6_trl1", int'(rx_q[last]), 8'hAA);

        // random contents with random backpressure
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NW; k++) wmem[k] = 8'($urandom);
            for (int b = 0; b < NB; b++) bmem[b] = $urandom;
            start_frame(40 + 30 * r);
            finish_frame("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
